// File: rtl/noise_burst_env_if.sv
// Sample-rate handshake bundle between the noise source/controller and the burst envelope.
interface noise_burst_env_if #(
  parameter int LEN_W = 8
);
  logic                    sample_en;
  logic signed [15:0]      noise_in;
  logic                    trigger;
  logic        [6:0]       velocity;
  logic        [LEN_W-1:0] burst_len;
  logic signed [15:0]      sample_out;
  logic                    sample_valid;
  logic                    busy;

  modport master (
    output sample_en, noise_in, trigger, velocity, burst_len,
    input  sample_out, sample_valid, busy
  );

  modport slave (
    input  sample_en, noise_in, trigger, velocity, burst_len,
    output sample_out, sample_valid, busy
  );
endinterface

// File: rtl/noise_burst_env.sv
// Velocity-scaled noise burst with linear power-of-2 fade; one registered sample per sample_en
// (latency 1 clk); no backpressure, the sample_en strobe paces everything.
module noise_burst_env #(
  parameter int LEN_W      = 8,
  parameter int FADE_SHIFT = 4
) (
  input logic              clk,
  input logic              reset,
  noise_burst_env_if.slave bus
);
  localparam int FW = FADE_SHIFT + 1;
  localparam int PW = 16 + FW + 1;
  localparam logic [FW-1:0] FADE_LOAD = {1'b1, {FADE_SHIFT{1'b0}}};

  typedef enum logic [1:0] {IDLE, BURST, FADE} state_t;

  state_t             state_q, state_d;
  logic [6:0]         vel_q, vel_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [FW-1:0]      fade_cnt_q, fade_cnt_d;
  logic signed [15:0] sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;

  logic signed [23:0] prod;
  logic signed [15:0] scaled;
  logic signed [PW-1:0] fprod;
  logic signed [15:0] faded;
  logic               unused_bits;

  // Arithmetic shift then truncate is just a bit slice of the full product.
  assign prod   = bus.noise_in * $signed({1'b0, vel_q});
  assign scaled = prod[22:7];
  assign fprod  = scaled * $signed({1'b0, fade_cnt_q});
  assign faded  = fprod[FADE_SHIFT+15:FADE_SHIFT];
  assign unused_bits = ^{prod[23], prod[6:0], fprod[PW-1:FADE_SHIFT+16], fprod[FADE_SHIFT-1:0]};

  always_comb begin
    state_d        = state_q;
    vel_d          = vel_q;
    len_cnt_d      = len_cnt_q;
    fade_cnt_d     = fade_cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = bus.sample_en;

    if (bus.sample_en) begin
      case (state_q)
        BURST: begin
          sample_out_d = scaled;
          if (len_cnt_q == LEN_W'(1)) begin
            state_d    = FADE;
            fade_cnt_d = FADE_LOAD;
          end else begin
            len_cnt_d = len_cnt_q - LEN_W'(1);
          end
        end
        FADE: begin
          sample_out_d = faded;
          fade_cnt_d   = fade_cnt_q - FW'(1);
          if (fade_cnt_q == FW'(1)) state_d = IDLE;
        end
        default: sample_out_d = '0;
      endcase
    end

    // A trigger overrides counter updates; the sample above still used the old burst.
    if (bus.trigger) begin
      vel_d      = bus.velocity;
      len_cnt_d  = bus.burst_len;
      fade_cnt_d = FADE_LOAD;
      state_d    = (bus.burst_len != '0) ? BURST : FADE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      vel_q          <= '0;
      len_cnt_q      <= '0;
      fade_cnt_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vel_q          <= vel_d;
      len_cnt_q      <= len_cnt_d;
      fade_cnt_q     <= fade_cnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.busy         = busy_q;
endmodule
